// File: rtl/display_pkg.sv
// Shared 7-segment definitions for the display encoder and decoder.
// Segment order within a digit is g,f,e,d,c,b,a (a = LSB), active-low.
package display_pkg;

    localparam int SEG_W  = 7;
    localparam int DISP_W = 14;

    // Ones-digit patterns
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;

    // Tens-digit patterns: blank means 0, the "1" glyph means 1
    localparam logic [SEG_W-1:0] SEG_BLANK    = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_TENS_ONE = 7'b1111001;

    typedef enum logic {
        TRACK  = 1'b0,
        LOCKED = 1'b1
    } track_state_t;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational decode of one active-low 7-segment digit to 0..9.
// legal is low for any pattern that is not one of SEG_0..SEG_9.
module seg_digit_decode
    import display_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       digit,
    output logic             legal
);

    // Pattern lookup; anything unrecognised decodes to 0 and is flagged illegal
    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/display_decode.sv
// Read-back decoder for the two-digit active-low 7-segment bus.
// Waits for STABLE_CYCLES identical samples, decodes the pattern to 0..15
// (or flags an error) and offers it on a valid/ready handshake.
// Build option: DISPLAY_DECODE_SYNC_EN selects a 2-flop input synchronizer
// instead of a single sampling register.
module display_decode
    import display_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DISP_W-1:0] seg_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [3:0]        out_data,
    output logic              out_err,
    output logic              overrun
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [DISP_W-1:0] seg_s;

`ifdef DISPLAY_DECODE_SYNC_EN
    logic [DISP_W-1:0] sync_p0;
    logic [DISP_W-1:0] sync_p1;

    // Two-flop synchronizer for sources outside this clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= seg_in;
            sync_p1 <= sync_p0;
        end
    end

    assign seg_s = sync_p1;
`else
    logic [DISP_W-1:0] sync_p0;

    // Single sampling register for same-clock loopback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '1;
        end else begin
            sync_p0 <= seg_in;
        end
    end

    assign seg_s = sync_p0;
`endif

    // Decode of the current sample; on an accepting edge seg_s equals the
    // pattern that becomes (or already is) seg_prev, so it is decoded directly.
    logic [3:0]       ones_digit;
    logic             ones_legal;
    logic [SEG_W-1:0] tens_seg;
    logic             tens_legal;
    logic             tens_one;
    logic [4:0]       value;
    logic             dec_legal;
    logic [3:0]       dec_data;

    seg_digit_decode u_ones (
        .seg   (seg_s[SEG_W-1:0]),
        .digit (ones_digit),
        .legal (ones_legal)
    );

    assign tens_seg = seg_s[DISP_W-1:SEG_W];

    // Tens digit is either blank (0) or the "1" glyph; combine into 0..19
    always_comb begin
        tens_one   = (tens_seg == SEG_TENS_ONE);
        tens_legal = tens_one || (tens_seg == SEG_BLANK);
        value      = {1'b0, ones_digit} + (tens_one ? 5'd10 : 5'd0);
        dec_legal  = ones_legal && tens_legal && (value <= 5'd15);
        dec_data   = dec_legal ? value[3:0] : 4'd0;
    end

    // Stability tracker
    track_state_t      state, state_nxt;
    logic [7:0]        cnt, cnt_nxt, cnt_inc;
    logic [DISP_W-1:0] seg_prev, prev_nxt;
    logic              accept;

    // State register, stability counter and last-seen pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOCKED;
            cnt      <= 8'd0;
            seg_prev <= '1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            seg_prev <= prev_nxt;
        end
    end

    // Any change restarts the count; a locked pattern never counts again,
    // so a held pattern is reported only once.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        prev_nxt  = seg_prev;
        accept    = 1'b0;
        cnt_inc   = cnt + 8'd1;
        if (seg_s != seg_prev) begin
            prev_nxt  = seg_s;
            cnt_nxt   = 8'd1;
            state_nxt = TRACK;
            accept    = (STABLE_LIM == 8'd1);
        end else if (state == TRACK) begin
            cnt_nxt = cnt_inc;
            accept  = (cnt_inc == STABLE_LIM);
        end
        if (accept) begin
            state_nxt = LOCKED;
        end
    end

    // Result register with valid/ready handshake; a new acceptance always wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 4'd0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= dec_data;
            out_err   <= !dec_legal;
            overrun   <= out_valid && !out_ready;
        end else begin
            overrun <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_decode.sv
// Testbench for display_decode: decode table, hand-written corner sequences
// and randomized traffic against a behavioural model.
module tb_display_decode;

    localparam int STABLE = 4;
`ifdef DISPLAY_DECODE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 1;
`endif
    localparam int LAT = SYNC + STABLE;

    logic        clk;
    logic        rst_n;
    logic [13:0] seg_in;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_err;
    logic        overrun;

    display_decode #(.STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Glyphs spelled out independently of the design package
    logic [6:0] ones_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] T_BLANK = 7'b1111111;
    localparam logic [6:0] T_ONE   = 7'b1111001;

    // Behavioural model: value = tens*10 + ones, legal only up to 15
    function automatic void ref_decode(input logic [13:0] p, output logic [3:0] d, output logic e);
        int tens;
        int ones;
        tens = -1;
        ones = -1;
        if (p[13:7] == T_BLANK) tens = 0;
        else if (p[13:7] == T_ONE) tens = 1;
        for (int i = 0; i < 10; i++) if (p[6:0] == ones_tab[i]) ones = i;
        if (tens >= 0 && ones >= 0 && tens * 10 + ones <= 15) begin
            d = 4'(tens * 10 + ones);
            e = 1'b0;
        end else begin
            d = 4'd0;
            e = 1'b1;
        end
    endfunction

    logic [13:0] m_pipe [SYNC];
    logic [13:0] m_last;
    int          m_run;     // length of the current run of identical samples; 0 = run left over from reset
    logic        m_valid;
    logic [3:0]  m_data;
    logic        m_err;
    logic        m_over;

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_pipe[i] = 14'h3FFF;
        m_last  = 14'h3FFF;
        m_run   = 0;
        m_valid = 1'b0;
        m_data  = 4'd0;
        m_err   = 1'b0;
        m_over  = 1'b0;
    endtask

    task automatic model_edge(input logic [13:0] seg, input logic rdy);
        logic [13:0] cur;
        logic        moved;
        logic        acc;
        cur   = m_pipe[SYNC-1];
        moved = 1'b0;
        for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = seg;
        if (cur != m_last) begin
            m_last = cur;
            m_run  = 1;
            moved  = 1'b1;
        end else if (m_run > 0 && m_run <= STABLE) begin
            m_run++;
            moved = 1'b1;
        end
        acc    = moved && (m_run == STABLE);
        m_over = 1'b0;
        if (acc) begin
            m_over  = m_valid && !rdy;
            m_valid = 1'b1;
            ref_decode(cur, m_data, m_err);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic [13:0] seg, input logic rdy);
        @(negedge clk);
        seg_in    = seg;
        out_ready = rdy;
        @(posedge clk);
        model_edge(seg, rdy);
        #1;
        check("valid", out_valid, m_valid);
        check("data", out_data, m_data);
        check("err", out_err, m_err);
        check("overrun", overrun, m_over);
    endtask

    // Reset is asserted between edges so the output check proves it is asynchronous.
    // The edge while rst_n is released sees an all-blank bus, which changes nothing.
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        seg_in    = 14'h3FFF;
        out_ready = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_err", out_err, 0);
        check("rst_overrun", overrun, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [13:0] seg;
        logic [3:0]  data;
        logic        err;
    } vec_t;

    localparam int NV = 22;
    vec_t tab [NV];

    function automatic vec_t mk(input logic [6:0] t, input logic [6:0] o, input int d, input logic e);
        vec_t v;
        v.seg  = {t, o};
        v.data = 4'(d);
        v.err  = e;
        return v;
    endfunction

    int reports;
    int at;
    int overs;
    logic [3:0] got_d;
    logic got_e;

    initial begin
        rst_n     = 1'b1;
        seg_in    = 14'h3FFF;
        out_ready = 1'b0;
        model_reset();

        tab[0]  = '{seg: 14'h3F92, data: 4'd5,  err: 1'b0};
        tab[1]  = '{seg: 14'h3CB0, data: 4'd13, err: 1'b0};
        for (int i = 0; i < 10; i++) tab[2 + i] = mk(T_BLANK, ones_tab[i], i, 1'b0);
        tab[12] = mk(T_ONE, ones_tab[0], 10, 1'b0);
        tab[13] = mk(T_ONE, ones_tab[1], 11, 1'b0);
        tab[14] = mk(T_ONE, ones_tab[2], 12, 1'b0);
        tab[15] = mk(T_ONE, ones_tab[4], 14, 1'b0);
        tab[16] = mk(T_ONE, ones_tab[5], 15, 1'b0);
        tab[17] = mk(T_ONE, ones_tab[6], 0, 1'b1);
        tab[18] = mk(T_ONE, ones_tab[7], 0, 1'b1);
        tab[19] = mk(T_BLANK, 7'b1010101, 0, 1'b1);
        tab[20] = mk(7'b0000000, ones_tab[5], 0, 1'b1);
        tab[21] = mk(T_BLANK, T_BLANK, 0, 1'b1);

        // Blank bus after reset is never reported
        do_reset();
        reports = 0;
        overs   = 0;
        for (int i = 0; i < 20; i++) begin
            step(14'h3FFF, 1'b1);
            if (out_valid) reports++;
            if (overrun) overs++;
        end
        check("idle_reports", reports, 0);
        check("idle_overrun", overs, 0);

        // Decode table: one report per pattern, LAT edges after it is driven
        for (int v = 0; v < NV; v++) begin
            reports = 0;
            at      = -1;
            got_d   = 4'd0;
            got_e   = 1'b0;
            for (int i = 0; i < LAT + 6; i++) begin
                step(tab[v].seg, 1'b1);
                if (out_valid) begin
                    reports++;
                    if (at < 0) at = i;
                    got_d = out_data;
                    got_e = out_err;
                end
            end
            check("tab_reports", reports, 1);
            check("tab_latency", at, LAT - 1);
            check("tab_data", got_d, tab[v].data);
            check("tab_err", got_e, tab[v].err);
        end

        // Glitch mid-count is discarded; 13 is reported STABLE after it ends
        do_reset();
        reports = 0;
        at      = -1;
        got_d   = 4'd0;
        for (int i = 0; i < 2; i++) begin
            step(14'h3CB0, 1'b1);
            if (out_valid) reports++;
        end
        for (int i = 0; i < 3; i++) begin
            step({T_ONE, ones_tab[8]}, 1'b1);
            if (out_valid) reports++;
        end
        for (int i = 0; i < LAT + 8; i++) begin
            step(14'h3CB0, 1'b1);
            if (out_valid) begin
                reports++;
                if (at < 0) at = i;
                got_d = out_data;
            end
        end
        check("glitch_reports", reports, 1);
        check("glitch_latency", at, LAT - 1);
        check("glitch_data", got_d, 13);

        // Overrun: 2 left pending, 9 overwrites it
        do_reset();
        for (int i = 0; i < LAT + 1; i++) step({T_BLANK, ones_tab[2]}, 1'b0);
        check("ovr_first_valid", out_valid, 1);
        check("ovr_first_data", out_data, 2);
        overs = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            step({T_BLANK, ones_tab[9]}, 1'b0);
            if (overrun) overs++;
        end
        check("ovr_pulses", overs, 1);
        check("ovr_valid", out_valid, 1);
        check("ovr_data", out_data, 9);
        step({T_BLANK, ones_tab[9]}, 1'b1);
        check("ovr_drain", out_valid, 0);

        // Reset mid-count, then with a result pending
        do_reset();
        for (int i = 0; i < 2; i++) step(14'h3F92, 1'b1);
        do_reset();
        for (int i = 0; i < LAT + 1; i++) step(14'h3CB0, 1'b0);
        check("pend_valid", out_valid, 1);
        do_reset();
        reports = 0;
        for (int i = 0; i < 15; i++) begin
            step(14'h3FFF, 1'b1);
            if (out_valid) reports++;
        end
        check("post_rst_reports", reports, 0);

        // Randomized traffic against the model
        do_reset();
        begin
            logic [13:0] pat;
            int          sel;
            int          hold;
            pat = 14'h3FFF;
            for (int n = 0; n < 300; n++) begin
                sel = int'($urandom_range(0, 3));
                if (sel <= 1) pat = tab[$urandom_range(0, NV - 1)].seg;
                else if (sel == 2) pat = 14'($urandom);
                hold = int'($urandom_range(1, STABLE + 3));
                for (int i = 0; i < hold; i++) step(pat, 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
